instr_fetch_unit: RTL and testbench

//   Initiator side of the memory controller's instruction port. Generates sequential

---
 rtl/instr_fetch_unit.sv | 180 ++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Initiator side of the memory controller instruction port. Issues sequential
//   word fetches over the instr_enable/instr_valid handshake and queues each
//   returned word, tagged with its PC, in a small FIFO for the decode stage.
//   A redirect flushes the FIFO, restarts fetching at redirect_pc, and discards
//   any response that is still in flight.
//
// Parameters
//   RESET_PC      PC of the first fetch after reset (word aligned)
//   DEPTH         fetch FIFO entries, power of 2, >= 2
//
// Ports
//   clk           system clock, all state on posedge
//   rst           synchronous reset, active-high
//   instr_enable  request to the memory controller instruction port
//   instr_valid   one-cycle response strobe from the controller
//   instr_addr    word-aligned fetch byte address
//   instr_result  fetched word, qualified by instr_valid
//   fetch_valid   FIFO head holds a valid entry
//   fetch_ready   decode accepts the head (pop = fetch_valid & fetch_ready)
//   fetch_pc      PC of the FIFO head
//   fetch_instr   instruction word of the FIFO head
//   redirect      flush and restart fetching at redirect_pc
//   redirect_pc   new fetch PC, bits [1:0] treated as zero
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        instr_enable,
  input  logic        instr_valid,
  output logic [31:0] instr_addr,
  input  logic [31:0] instr_result,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_instr,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no request on the port
    REQ  = 2'd1,  // request whose response will be kept
    DROP = 2'd2   // request whose response will be thrown away
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        addr_q, addr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        mem_pc_q    [DEPTH];
  logic [31:0]        mem_instr_q [DEPTH];

  logic               pop;
  logic               push;
  logic [CNT_W-1:0]   cnt_n;
  logic [31:0]        target_pc;

  // Masking instead of slicing keeps every redirect_pc bit in use.
  assign target_pc = redirect_pc & 32'hFFFF_FFFC;

  assign pop   = fetch_valid & fetch_ready;
  // Occupancy as it will be once this cycle's pop has left.
  assign cnt_n = count_q - CNT_W'(pop);

  assign instr_enable = (state_q == REQ) || (state_q == DROP);
  assign instr_addr   = addr_q;
  assign fetch_valid  = (count_q != '0);
  assign fetch_pc     = mem_pc_q[rd_ptr_q];
  assign fetch_instr  = mem_instr_q[rd_ptr_q];

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    push     = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    case (state_q)
      IDLE: begin
        if (redirect) begin
          pc_d    = target_pc;
          addr_d  = target_pc;
          state_d = REQ;
        end else if (cnt_n < CNT_W'(DEPTH)) begin
          addr_d  = pc_q;
          state_d = REQ;
        end
      end
      REQ: begin
        if (redirect) begin
          pc_d = target_pc;
          if (instr_valid) begin
            addr_d = target_pc;
          end else begin
            // Old address must stay on the port until its response arrives.
            state_d = DROP;
          end
        end else if (instr_valid) begin
          push = 1'b1;
          pc_d = pc_q + 32'd4;
          // Keep streaming only if the FIFO still has room after this push.
          if (cnt_n < CNT_W'(DEPTH - 1)) begin
            addr_d = pc_q + 32'd4;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        if (redirect) begin
          pc_d = target_pc;
          // The stale response completing now frees the port; no further
          // response would arrive if we stayed in DROP.
          if (instr_valid) begin
            addr_d  = target_pc;
            state_d = REQ;
          end
        end else if (instr_valid) begin
          addr_d  = pc_q;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    if (redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = cnt_n + CNT_W'(push);
    end
  end

  // NOTE: registers take their next value with non-blocking assignments so all
  // flops update together on the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC & 32'hFFFF_FFFC;
      addr_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: FIFO storage is not reset; an entry is only read while count_q says
  // it was written, so its power-up contents never matter.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc_q[wr_ptr_q]    <= pc_q;
      mem_instr_q[wr_ptr_q] <= instr_result;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Self-checking bench for instr_fetch_unit: a cycle table for the basic
//   streaming/back-pressure/redirect cases, hand sequences for full-FIFO
//   redirect, reset mid-request and PC wrap, then a randomized run checked
//   against a transaction-level model of the fetch stream.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_enable;
  logic        instr_valid;
  logic [31:0] instr_addr;
  logic [31:0] instr_result;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr;
  logic        redirect;
  logic [31:0] redirect_pc;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_enable (instr_enable),
    .instr_valid  (instr_valid),
    .instr_addr   (instr_addr),
    .instr_result (instr_result),
    .fetch_valid  (fetch_valid),
    .fetch_ready  (fetch_ready),
    .fetch_pc     (fetch_pc),
    .fetch_instr  (fetch_instr),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc)
  );

  typedef struct {
    logic        valid;
    logic [31:0] result;
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        en;
    logic        chk_addr;
    logic [31:0] addr;
    logic        fv;
    logic [31:0] pc;
    logic [31:0] instr;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  // Memory contents seen by the fetch unit.
  function automatic logic [31:0] w(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic vec_t mk(input logic v, input logic [31:0] res, input logic rdy,
                              input logic rd, input logic [31:0] rp, input logic en,
                              input logic ca, input logic [31:0] ad, input logic fv,
                              input logic [31:0] pc, input logic [31:0] ins);
    vec_t r;
    r.valid = v;  r.result = res; r.ready = rdy; r.redir = rd; r.rpc = rp;
    r.en = en;    r.chk_addr = ca; r.addr = ad;  r.fv = fv;    r.pc = pc;
    r.instr = ins;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply inputs, let one edge pass, return #1 after it.
  task automatic drive(input logic v, input logic [31:0] res, input logic rdy,
                       input logic rd, input logic [31:0] rp);
    instr_valid  = v;
    instr_result = res;
    fetch_ready  = rdy;
    redirect     = rd;
    redirect_pc  = rp;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string n, input logic en, input logic ca,
                            input logic [31:0] ad, input logic fv, input logic [31:0] pc);
    check({n, " enable"}, 32'(instr_enable), 32'(en));
    if (ca) check({n, " addr"}, instr_addr, ad);
    check({n, " fetch_valid"}, 32'(fetch_valid), 32'(fv));
    if (fv) begin
      check({n, " fetch_pc"}, fetch_pc, pc);
      check({n, " fetch_instr"}, fetch_instr, w(pc));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
  endtask

  vec_t        vecs[15];
  ent_t        mq[$];
  logic [31:0] model_pc, req_addr, res_r, rp_r;
  logic        req_active, stale, v_r, rd_r, rdy_r, post_push;
  int          lat, pushes;

  initial begin
    // Cycle table from reset: streaming, full FIFO, single pop, redirects.
    vecs[0]  = mk(0, 32'h0,          0, 0, 32'h0,   1, 1, 32'h000, 0, 32'h0,   32'h0);
    vecs[1]  = mk(0, 32'h0,          0, 0, 32'h0,   1, 1, 32'h000, 0, 32'h0,   32'h0);
    vecs[2]  = mk(1, w(32'h0),       0, 0, 32'h0,   1, 1, 32'h004, 1, 32'h0,   w(32'h0));
    vecs[3]  = mk(1, w(32'h4),       0, 0, 32'h0,   1, 1, 32'h008, 1, 32'h0,   w(32'h0));
    vecs[4]  = mk(1, w(32'h8),       0, 0, 32'h0,   1, 1, 32'h00C, 1, 32'h0,   w(32'h0));
    vecs[5]  = mk(1, w(32'hC),       0, 0, 32'h0,   0, 0, 32'h000, 1, 32'h0,   w(32'h0));
    vecs[6]  = mk(0, 32'h0,          0, 0, 32'h0,   0, 0, 32'h000, 1, 32'h0,   w(32'h0));
    vecs[7]  = mk(0, 32'h0,          1, 0, 32'h0,   1, 1, 32'h010, 1, 32'h4,   w(32'h4));
    vecs[8]  = mk(0, 32'h0,          0, 1, 32'h103, 1, 1, 32'h010, 0, 32'h0,   32'h0);
    vecs[9]  = mk(0, 32'h0,          0, 0, 32'h0,   1, 1, 32'h010, 0, 32'h0,   32'h0);
    vecs[10] = mk(1, 32'hDEAD_BEEF,  0, 0, 32'h0,   1, 1, 32'h100, 0, 32'h0,   32'h0);
    vecs[11] = mk(1, w(32'h100),     0, 0, 32'h0,   1, 1, 32'h104, 1, 32'h100, w(32'h100));
    vecs[12] = mk(1, w(32'h104),     0, 1, 32'h200, 1, 1, 32'h200, 0, 32'h0,   32'h0);
    vecs[13] = mk(1, w(32'h200),     1, 0, 32'h0,   1, 1, 32'h204, 1, 32'h200, w(32'h200));
    vecs[14] = mk(0, 32'h0,          1, 0, 32'h0,   1, 1, 32'h204, 0, 32'h0,   32'h0);

    instr_valid = 1'b0; instr_result = '0; fetch_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    do_reset();
    expect_out("reset", 1'b0, 1'b1, 32'h0, 1'b0, 32'h0);

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].valid, vecs[i].result, vecs[i].ready, vecs[i].redir, vecs[i].rpc);
      check($sformatf("vec%0d enable", i), 32'(instr_enable), 32'(vecs[i].en));
      if (vecs[i].chk_addr) check($sformatf("vec%0d addr", i), instr_addr, vecs[i].addr);
      check($sformatf("vec%0d fetch_valid", i), 32'(fetch_valid), 32'(vecs[i].fv));
      if (vecs[i].fv) begin
        check($sformatf("vec%0d fetch_pc", i), fetch_pc, vecs[i].pc);
        check($sformatf("vec%0d fetch_instr", i), fetch_instr, vecs[i].instr);
      end
    end

    // Fill the FIFO, then pop and redirect in the same cycle.
    drive(1'b1, w(32'h204), 1'b0, 1'b0, 32'h0);
    expect_out("fill1", 1'b1, 1'b1, 32'h208, 1'b1, 32'h204);
    drive(1'b1, w(32'h208), 1'b0, 1'b0, 32'h0);
    expect_out("fill2", 1'b1, 1'b1, 32'h20C, 1'b1, 32'h204);
    drive(1'b1, w(32'h20C), 1'b0, 1'b0, 32'h0);
    expect_out("fill3", 1'b1, 1'b1, 32'h210, 1'b1, 32'h204);
    drive(1'b1, w(32'h210), 1'b0, 1'b0, 32'h0);
    expect_out("fill4", 1'b0, 1'b0, 32'h0, 1'b1, 32'h204);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h300);
    expect_out("full_pop_redirect", 1'b1, 1'b1, 32'h300, 1'b0, 32'h0);
    drive(1'b1, w(32'h300), 1'b0, 1'b0, 32'h0);
    expect_out("after_flush", 1'b1, 1'b1, 32'h304, 1'b1, 32'h300);

    // Reset in the middle of a request, then PC wrap.
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    expect_out("mid_reset", 1'b0, 1'b1, 32'h0, 1'b0, 32'h0);
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    expect_out("post_reset", 1'b1, 1'b1, RESET_PC, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    expect_out("wrap_drop", 1'b1, 1'b1, RESET_PC, 1'b0, 32'h0);
    drive(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
    expect_out("wrap_req", 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    drive(1'b1, w(32'hFFFF_FFFC), 1'b0, 1'b0, 32'h0);
    expect_out("wrap_next", 1'b1, 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC);

    // Randomized run against a transaction-level model: each request either
    // gets pushed with the next sequential PC, or is discarded if a redirect
    // was seen at any point while it was on the port.
    do_reset();
    model_pc = RESET_PC; mq.delete(); req_active = 1'b0; stale = 1'b0;
    lat = 0; pushes = 0; req_addr = '0; post_push = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rd_r  = ($urandom_range(0, 19) == 0);
      rp_r  = $urandom;
      rdy_r = ($urandom_range(0, 2) != 0);
      v_r   = 1'b0;
      if (req_active) begin
        check("rnd enable held", 32'(instr_enable), 32'h1);
        check("rnd addr held", instr_addr, req_addr);
      end else if (instr_enable) begin
        req_active = 1'b1;
        req_addr   = instr_addr;
        lat        = $urandom_range(0, 2);
        stale      = 1'b0;
      end
      if (req_active) begin
        if (lat == 0) v_r = 1'b1;
        else lat--;
      end
      res_r = v_r ? w(instr_addr) : $urandom;

      post_push = 1'b0;
      if (rd_r) begin
        mq.delete();
        model_pc = rp_r & 32'hFFFF_FFFC;
        if (req_active) stale = 1'b1;
      end else if (rdy_r && mq.size() > 0) begin
        void'(mq.pop_front());
      end
      if (v_r) begin
        if (!stale) begin
          check("rnd request addr", instr_addr, model_pc);
          mq.push_back('{model_pc, w(model_pc)});
          model_pc  = model_pc + 32'd4;
          pushes++;
          post_push = 1'b1;
        end
        req_active = 1'b0;
      end

      drive(v_r, res_r, rdy_r, rd_r, rp_r);

      // After a kept response the port keeps streaming only while room remains.
      if (post_push)
        check("rnd stream continue", 32'(instr_enable), 32'(mq.size() < DEPTH));
      if (mq.size() > 0) begin
        check("rnd fetch_valid", 32'(fetch_valid), 32'h1);
        check("rnd fetch_pc", fetch_pc, mq[0].pc);
        check("rnd fetch_instr", fetch_instr, mq[0].instr);
      end else begin
        check("rnd fetch_valid", 32'(fetch_valid), 32'h0);
      end
    end
    check("rnd progress", 32'(pushes > 100), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
